// File: rtl/seg7_scan_mux.sv
// Scans four latched 7-segment patterns onto one shared segment bus.
// Patterns are latched per frame; each slot opens with a blanking gap.
module seg7_scan_mux #(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lz_en,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  output logic [6:0] seg_out,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] AN_MASK  = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0] ZERO     = 7'b1111110;

  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [6:0]    r_sh [4];
  logic          r_lz;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_tick;

  logic          w_run_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [1:0]    w_idx_nx;
  logic          w_load;
  logic [6:0]    w_in [4];
  logic [6:0]    w_sh_nx [4];
  logic          w_lz_nx;
  logic          w_lzb;
  logic          w_on;
  logic [6:0]    w_seg_raw;
  logic [3:0]    w_an_raw;

  assign w_in[0] = seg1;
  assign w_in[1] = seg2;
  assign w_in[2] = seg3;
  assign w_in[3] = seg4;

  always_comb begin
    w_run_nx = r_run;
    w_cnt_nx = r_cnt;
    w_idx_nx = r_idx;
    w_load   = 1'b0;
    if (!r_run) begin
      if (en) begin
        w_run_nx = 1'b1;
        w_cnt_nx = '0;
        w_idx_nx = 2'd0;
        w_load   = 1'b1;
      end
    end else if (!en) begin
      w_run_nx = 1'b0;
      w_cnt_nx = '0;
      w_idx_nx = 2'd0;
    end else if (r_cnt == LAST) begin
      w_cnt_nx = '0;
      w_idx_nx = r_idx + 2'd1;
      w_load   = (r_idx == 2'd3);
    end else begin
      w_cnt_nx = r_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_sh_nx[i] = w_load ? w_in[i] : r_sh[i];
    end
    w_lz_nx = w_load ? lz_en : r_lz;
  end

  // Outputs are computed from next state so pins track cnt/idx without lag.
  always_comb begin
    w_lzb = w_lz_nx &&
            (((w_idx_nx == 2'd1) && (w_sh_nx[1] == ZERO)) ||
             ((w_idx_nx == 2'd3) && (w_sh_nx[3] == ZERO)));
    w_on      = w_run_nx && (w_cnt_nx >= BLANK) && !w_lzb;
    w_seg_raw = w_on ? w_sh_nx[w_idx_nx] : 7'd0;
    w_an_raw  = w_on ? (4'b0001 << w_idx_nx) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_lz   <= 1'b0;
      r_seg  <= SEG_MASK;
      r_an   <= AN_MASK;
      r_tick <= 1'b0;
      for (int i = 0; i < 4; i++) r_sh[i] <= 7'd0;
    end else begin
      r_run  <= w_run_nx;
      r_cnt  <= w_cnt_nx;
      r_idx  <= w_idx_nx;
      r_lz   <= w_lz_nx;
      r_seg  <= w_seg_raw ^ SEG_MASK;
      r_an   <= w_an_raw ^ AN_MASK;
      r_tick <= w_load;
      for (int i = 0; i < 4; i++) r_sh[i] <= w_sh_nx[i];
    end
  end

  assign seg_out    = r_seg;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: expected pin states per cycle queued
// from tables, popped and compared as the scan reaches each cycle.
module tb_seg7_scan_mux;

  typedef struct packed {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       tk;
  } vec_t;

  localparam logic [3:0] OA = 4'hF;
  localparam logic [6:0] OS = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       lz_en = 1'b0;
  logic [6:0] seg1 = 7'b1110000;
  logic [6:0] seg2 = 7'b1111110;
  logic [6:0] seg3 = 7'b0110000;
  logic [6:0] seg4 = 7'b1101101;
  logic [6:0] seg_out;
  logic [3:0] an;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .CLK_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
    .seg_out(seg_out), .an(an), .frame_tick(frame_tick)
  );

  task automatic chk(string nm, int c, vec_t e);
    total++;
    if (an !== e.an || seg_out !== e.seg || frame_tick !== e.tk) begin
      bad++;
      $display("FAIL %s cyc=%0d got an=%b seg=%b tk=%b want an=%b seg=%b tk=%b",
               nm, c, an, seg_out, frame_tick, e.an, e.seg, e.tk);
    end
  endtask

  task automatic inv(string nm, int c);
    total++;
    if ($countones(~an) > 1 || (an == OA && seg_out != OS)) begin
      bad++;
      $display("FAIL %s-inv cyc=%0d got an=%b seg=%b want one-hot-or-off",
               nm, c, an, seg_out);
    end
  endtask

  // Advance n cycles; per-test stimulus is applied after each compare.
  task automatic run(string nm, int tst, int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      inv(nm, c);
      while (exp_q.size() != 0 && exp_q[0].cyc == c) chk(nm, c, exp_q.pop_front());
      if (tst == 2 && c == 10) seg1 = 7'b0110000;
      if (tst == 4 && c == 5) lz_en = 1'b0;
      if (tst == 5 && c == 20) en = 1'b0;
      if (tst == 5 && c == 22) seg1 = 7'h7F;
      if (tst == 5 && c == 30) en = 1'b1;
      if (tst == 6 && c == 18) rst = 1'b1;
      if (tst == 6 && c == 20) rst = 1'b0;
    end
    while (exp_q.size() != 0) begin
      bad++; total++;
      $display("FAIL %s cyc=%0d got never-reached want checked", nm, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic stop();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t t2 [19] = '{
    '{0, OA, OS, 1'b1}, '{1, OA, OS, 1'b0},
    '{2, 4'b1110, 7'b0001111, 1'b0}, '{7, 4'b1110, 7'b0001111, 1'b0},
    '{8, OA, OS, 1'b0}, '{9, OA, OS, 1'b0},
    '{10, 4'b1101, 7'b0000001, 1'b0}, '{15, 4'b1101, 7'b0000001, 1'b0},
    '{16, OA, OS, 1'b0},
    '{18, 4'b1011, 7'b1001111, 1'b0}, '{23, 4'b1011, 7'b1001111, 1'b0},
    '{26, 4'b0111, 7'b0010010, 1'b0}, '{31, 4'b0111, 7'b0010010, 1'b0},
    '{32, OA, OS, 1'b1}, '{33, OA, OS, 1'b0},
    '{34, 4'b1110, 7'b1001111, 1'b0}, '{39, 4'b1110, 7'b1001111, 1'b0},
    '{40, OA, OS, 1'b0}, '{64, OA, OS, 1'b1}
  };

  vec_t t4 [10] = '{
    '{0, OA, OS, 1'b1}, '{2, 4'b1110, 7'b1001111, 1'b0},
    '{8, OA, OS, 1'b0}, '{10, OA, OS, 1'b0},
    '{12, OA, OS, 1'b0}, '{15, OA, OS, 1'b0},
    '{18, 4'b1011, 7'b1001111, 1'b0}, '{26, 4'b0111, 7'b0010010, 1'b0},
    '{31, 4'b0111, 7'b0010010, 1'b0}, '{42, 4'b1101, 7'b0000001, 1'b0}
  };

  vec_t t5 [8] = '{
    '{18, 4'b1011, 7'b1001111, 1'b0}, '{20, 4'b1011, 7'b1001111, 1'b0},
    '{21, OA, OS, 1'b0}, '{25, OA, OS, 1'b0},
    '{30, OA, OS, 1'b0}, '{31, OA, OS, 1'b1},
    '{33, 4'b1110, 7'b0000000, 1'b0}, '{41, 4'b1101, 7'b0000001, 1'b0}
  };

  vec_t t6 [6] = '{
    '{18, 4'b1011, 7'b1001111, 1'b0}, '{19, OA, OS, 1'b0},
    '{20, OA, OS, 1'b0}, '{21, OA, OS, 1'b1},
    '{23, 4'b1110, 7'b0000000, 1'b0}, '{31, 4'b1101, 7'b0000001, 1'b0}
  };

  initial begin
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset", c, '{c, OA, OS, 1'b0});
    end
    rst = 1'b0;
    foreach (t2[i]) exp_q.push_back(t2[i]);
    run("scan", 2, 65);

    stop();
    lz_en = 1'b1;
    en = 1'b1;
    foreach (t4[i]) exp_q.push_back(t4[i]);
    run("lz", 4, 43);

    stop();
    lz_en = 1'b1;
    seg1 = 7'b1111110;
    seg4 = 7'b1111110;
    en = 1'b1;
    exp_q.push_back('{2, 4'b1110, 7'b0000001, 1'b0});
    exp_q.push_back('{10, OA, OS, 1'b0});
    exp_q.push_back('{18, 4'b1011, 7'b1001111, 1'b0});
    exp_q.push_back('{26, OA, OS, 1'b0});
    exp_q.push_back('{29, OA, OS, 1'b0});
    run("lz-both", 0, 30);

    stop();
    lz_en = 1'b0;
    seg1 = 7'b1110000;
    seg4 = 7'b1101101;
    en = 1'b1;
    foreach (t5[i]) exp_q.push_back(t5[i]);
    run("en-drop", 5, 42);

    stop();
    en = 1'b1;
    foreach (t6[i]) exp_q.push_back(t6[i]);
    run("rst-mid", 6, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
